pad_io_ctrl: RTL and testbench

PAD_IO_CTRL -- requirements
Module: pad_io_ctrl

---
 rtl/pad_ctrl_pkg.sv | 18 +
 rtl/pad_sync.sv | 32 +++
 rtl/pad_io_ctrl.sv | 138 +++++++++++++
 tb/tb_pad_io_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pad_ctrl_pkg.sv
// Shared opcode encodings, FSM state type and default pad count for the pad I/O controller.
package pad_ctrl_pkg;

    localparam int NPADS_DEF = 14;

    typedef enum logic [1:0] {
        OP_WR_DIR  = 2'b00,
        OP_WR_OUT  = 2'b01,
        OP_RD_IN   = 2'b10,
        OP_CLR_EVT = 2'b11
    } pad_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_TURN = 1'b1
    } pad_state_e;

endpackage

// File: rtl/pad_sync.sv
// Vectorised two-flop synchroniser for asynchronous pad inputs, with a
// previous-value flop so that rising edges are detected on synchronised data only.
module pad_sync #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] pad_i,
    output logic [W-1:0] sync_o,
    output logic [W-1:0] rise_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;
    logic [W-1:0] prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= pad_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/pad_io_ctrl.sv
// Command-driven controller for bidirectional pads: direction changes go through a
// turnaround window so that no pad is driven from both sides, plus sticky edge events.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | accepting commands (cmd_ready high)
//   ST_TURN | direction change in progress; changed pads held undriven
module pad_io_ctrl
    import pad_ctrl_pkg::*;
#(
    parameter int NPADS    = NPADS_DEF,
    parameter int TURN_CYC = 2          // legal range 1..15 (4-bit counter)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [NPADS-1:0] cmd_data,
    output logic             rsp_valid,
    output logic [NPADS-1:0] rsp_data,
    output logic [NPADS-1:0] pad_o,
    output logic [NPADS-1:0] pad_oe,
    input  logic [NPADS-1:0] pad_i,
    output logic [NPADS-1:0] evt
);

    pad_state_e       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             ready_en_q;
    logic [NPADS-1:0] dir_q, dir_d;
    logic [NPADS-1:0] new_dir_q, new_dir_d;
    logic [NPADS-1:0] pad_oe_q, pad_oe_d;
    logic [NPADS-1:0] pad_o_q, pad_o_d;
    logic [NPADS-1:0] evt_q, evt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [NPADS-1:0] rsp_data_q, rsp_data_d;
    logic [NPADS-1:0] sync_i;
    logic [NPADS-1:0] rise;
    logic [NPADS-1:0] mask;
    logic             accept;

    pad_sync #(.W(NPADS)) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .pad_i  (pad_i),
        .sync_o (sync_i),
        .rise_o (rise)
    );

    // ready_en_q keeps cmd_ready low during reset and until the first edge after release.
    assign cmd_ready = ready_en_q && (state_q == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign mask      = dir_q ^ cmd_data;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        new_dir_d   = new_dir_q;
        pad_oe_d    = pad_oe_q;
        pad_o_d     = pad_o_q;
        evt_d       = evt_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (pad_op_e'(cmd_op))
                        OP_WR_DIR: begin
                            if (mask != '0) begin
                                new_dir_d = cmd_data;
                                pad_oe_d  = pad_oe_q & ~mask;
                                cnt_d     = 4'(TURN_CYC);
                                state_d   = ST_TURN;
                            end
                        end
                        OP_WR_OUT:  pad_o_d = cmd_data;
                        OP_RD_IN: begin
                            rsp_data_d  = sync_i;
                            rsp_valid_d = 1'b1;
                        end
                        OP_CLR_EVT: evt_d = evt_q & ~cmd_data;
                        default: ;
                    endcase
                end
            end
            ST_TURN: begin
                if (cnt_q <= 4'd1) begin
                    dir_d    = new_dir_q;
                    pad_oe_d = new_dir_q;
                    cnt_d    = 4'd0;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Set is applied after any clear so a coincident rise wins; dir_q is still the old value in TURN.
        evt_d = evt_d | (rise & ~dir_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            ready_en_q  <= 1'b0;
            dir_q       <= '0;
            new_dir_q   <= '0;
            pad_oe_q    <= '0;
            pad_o_q     <= '0;
            evt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_en_q  <= 1'b1;
            dir_q       <= dir_d;
            new_dir_q   <= new_dir_d;
            pad_oe_q    <= pad_oe_d;
            pad_o_q     <= pad_o_d;
            evt_q       <= evt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign pad_oe    = pad_oe_q;
    assign pad_o     = pad_o_q;
    assign evt       = evt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_pad_io_ctrl.sv
// Directed bench for pad_io_ctrl: reset, turnaround, output write, read-back,
// edge events with set-over-clear, and reset in the middle of a turnaround.
module tb_pad_io_ctrl;

    localparam int NPADS    = 14;
    localparam int TURN_CYC = 2;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [NPADS-1:0] cmd_data;
    logic             rsp_valid;
    logic [NPADS-1:0] rsp_data;
    logic [NPADS-1:0] pad_o;
    logic [NPADS-1:0] pad_oe;
    logic [NPADS-1:0] pad_i;
    logic [NPADS-1:0] evt;

    int n_assert = 0;
    int n_fail   = 0;

    pad_io_ctrl #(.NPADS(NPADS), .TURN_CYC(TURN_CYC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .pad_o     (pad_o),
        .pad_oe    (pad_oe),
        .pad_i     (pad_i),
        .evt       (evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Offer one command for exactly one edge (caller ensures cmd_ready is high).
    task automatic issue(input logic [1:0] op, input logic [NPADS-1:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
        cmd_data  = '0;
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = '0;
        pad_i     = '0;

        tick();
        tick();
        chk("rst_ready_low", 32'(cmd_ready), 32'h0);
        chk("rst_oe",        32'(pad_oe),    32'h0);

        // Reset release
        rst_n = 1'b1;
        tick();
        chk("rel_ready", 32'(cmd_ready), 32'h1);
        chk("rel_oe",    32'(pad_oe),    32'h0);
        chk("rel_o",     32'(pad_o),     32'h0);
        chk("rel_evt",   32'(evt),       32'h0);
        chk("rel_rspv",  32'(rsp_valid), 32'h0);

        // WR_DIR 0x0003 from dir=0: two turnaround cycles
        issue(2'b00, 14'h0003);
        chk("turn1_ready", 32'(cmd_ready), 32'h0);
        chk("turn1_oe",    32'(pad_oe),    32'h0);
        tick();
        chk("turn2_ready", 32'(cmd_ready), 32'h0);
        chk("turn2_oe",    32'(pad_oe),    32'h0);
        tick();
        chk("turn_done_ready", 32'(cmd_ready), 32'h1);
        chk("turn_done_oe",    32'(pad_oe),    32'h0003);

        // Same direction again: no turnaround
        issue(2'b00, 14'h0003);
        chk("same_dir_ready", 32'(cmd_ready), 32'h1);
        chk("same_dir_oe",    32'(pad_oe),    32'h0003);

        // WR_OUT
        issue(2'b01, 14'h2AAA);
        chk("wrout_o",  32'(pad_o),  32'h2AAA);
        chk("wrout_oe", 32'(pad_oe), 32'h0003);

        // RD_IN after pad_i settled; rising bits 2,4,5,9,12 are inputs so they flag events
        pad_i = 14'h1234;
        tick();
        tick();
        tick();
        issue(2'b10, 14'h0000);
        chk("rd_valid", 32'(rsp_valid), 32'h1);
        chk("rd_data",  32'(rsp_data),  32'h1234);
        chk("rd_evt",   32'(evt),       32'h1234);
        tick();
        chk("rd_valid_drop", 32'(rsp_valid), 32'h0);

        issue(2'b11, 14'h3FFF);
        chk("clr_all_evt", 32'(evt), 32'h0);

        // Rise on bit 5 appears in evt three edges after pad_i changes
        pad_i = '0;
        tick();
        tick();
        tick();
        pad_i = 14'h0020;
        tick();
        tick();
        chk("rise_evt_early", 32'(evt), 32'h0);
        tick();
        chk("rise_evt", 32'(evt), 32'h0020);

        // CLR_EVT coincident with a new rise on bit 5: set wins
        pad_i = '0;
        tick();
        tick();
        tick();
        pad_i = 14'h0020;
        tick();
        tick();
        issue(2'b11, 14'h0020);
        chk("clr_vs_set", 32'(evt), 32'h0020);
        issue(2'b11, 14'h0020);
        chk("clr_plain", 32'(evt), 32'h0);

        // Bit 0 is an output: its rise never flags
        pad_i = 14'h0021;
        tick();
        tick();
        tick();
        tick();
        chk("out_no_evt", 32'(evt), 32'h0);

        // dir 0x0003 -> 0x00FF: unchanged bits 0,1 keep driving through turnaround
        issue(2'b00, 14'h00FF);
        chk("ff_turn_oe", 32'(pad_oe), 32'h0003);
        tick();
        tick();
        chk("ff_done_oe", 32'(pad_oe), 32'h00FF);

        // WR_DIR 0x0000 then reset mid-turnaround
        issue(2'b00, 14'h0000);
        chk("to_in_oe",    32'(pad_oe),    32'h0);
        chk("to_in_ready", 32'(cmd_ready), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("midrst_oe",    32'(pad_oe),    32'h0);
        chk("midrst_o",     32'(pad_o),     32'h0);
        chk("midrst_ready", 32'(cmd_ready), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 32'(cmd_ready), 32'h1);
        chk("post_rst_oe",    32'(pad_oe),    32'h0);

        // dir must be 0 now: WR_DIR 0 causes no turnaround
        issue(2'b00, 14'h0000);
        chk("post_rst_dir0_ready", 32'(cmd_ready), 32'h1);
        chk("post_rst_dir0_oe",    32'(pad_oe),    32'h0);

        // pad_i still 0x0021; all pads inputs, so the re-synchronised rise flags both bits
        tick();
        tick();
        chk("post_rst_evt", 32'(evt), 32'h0021);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
